booth_r4_ctrl: RTL

//  FSM controller that sequences the 8-bit radix-4 Booth multiplier datapath.

---
 rtl/booth_r4_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/booth_r4_ctrl.sv
// ============================================================================
// booth_r4_ctrl
// ----------------------------------------------------------------------------
// Control FSM for an 8-bit radix-4 Booth multiplier datapath. It loads the
// operands, then runs ITER iterations. Each iteration:
//   - decodes the 3-bit Booth window {bit2,bit1,bit0} into an optional
//     add/subtract of 1x or 2x multiplicand;
//   - issues two 1-bit right shifts of the product/multiplier chain.
// A one-cycle done pulse marks a valid product.
//
// Optional feature macro: BOOTH_R4_CTRL_INTCNT_EN
//   defined   : the end-of-multiply test uses an internal CW-bit counter. LOAD
//               clears it and SHR2 increments it; eqcount is ignored.
//               Back-to-back multiplies need no reset.
//   undefined : the end test is the datapath's eqcount input. The datapath
//               counter clears only on rst, so rst must be pulsed between
//               multiplies.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   start      in   multiply request, sampled only in IDLE
//   bit2       in   Booth window MSB (multiplier bit i+1)
//   bit1       in   Booth window middle (multiplier bit i)
//   bit0       in   Booth window LSB (appended bit i-1)
//   eqcount    in   datapath iteration counter reached ITER
//   ldmp       out  load multiplicand register
//   ldmplier   out  load multiplier, clear appended bit
//   ldprd      out  write ALU result into product upper half
//   funcsel    out  ALU op: 1 = add, 0 = subtract
//   muxsel     out  ALU operand: 1 = 2x multiplicand, 0 = 1x
//   shr        out  shift product/multiplier chain right by one
//   inc_count  out  increment datapath iteration counter
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse, product valid
// ============================================================================
module booth_r4_ctrl #(
    parameter int ITER = 4,
    parameter int CW   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit2,
    input  logic bit1,
    input  logic bit0,
    input  logic eqcount,
    output logic ldmp,
    output logic ldmplier,
    output logic ldprd,
    output logic funcsel,
    output logic muxsel,
    output logic shr,
    output logic inc_count,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EVAL = 3'd2,
        S_SHR1 = 3'd3,
        S_SHR2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   end_test;

`ifdef BOOTH_R4_CTRL_INTCNT_EN
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          unused_eqcount;

    // The datapath's counter status is not needed when counting internally.
    assign unused_eqcount = eqcount;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_LOAD) begin
            cnt_d = '0;
        end else if (state_q == S_SHR2) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign end_test = (cnt_q == CW'(ITER));
`else
    assign end_test = eqcount;
`endif

    // State register. Outputs are decoded from state_q alone (plus the Booth
    // bits in EVAL), so an asynchronous rst drops every output immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ldmp      = 1'b0;
        ldmplier  = 1'b0;
        ldprd     = 1'b0;
        funcsel   = 1'b0;
        muxsel    = 1'b0;
        shr       = 1'b0;
        inc_count = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ldmp     = 1'b1;
                ldmplier = 1'b1;
                state_d  = S_EVAL;
            end
            S_EVAL: begin
                if (end_test) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHR1;
                    // Booth digit = -2*bit2 + bit1 + bit0. Zero digits skip the
                    // ALU write and leave funcsel/muxsel low.
                    unique case ({bit2, bit1, bit0})
                        3'b001, 3'b010: begin
                            ldprd   = 1'b1;
                            funcsel = 1'b1;
                        end
                        3'b011: begin
                            ldprd   = 1'b1;
                            funcsel = 1'b1;
                            muxsel  = 1'b1;
                        end
                        3'b100: begin
                            ldprd  = 1'b1;
                            muxsel = 1'b1;
                        end
                        3'b101, 3'b110: begin
                            ldprd = 1'b1;
                        end
                        default: begin
                            ldprd = 1'b0;
                        end
                    endcase
                end
            end
            S_SHR1: begin
                shr     = 1'b1;
                state_d = S_SHR2;
            end
            S_SHR2: begin
                shr       = 1'b1;
                inc_count = 1'b1;
                state_d   = S_EVAL;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
